// File: rtl/cfa_grad_scheduler_if.sv
// Pixel, gradient-unit and result handshake bundle for cfa_grad_scheduler.
// master = scheduler side, slave = line buffer / gradient unit / consumer side.
interface cfa_grad_scheduler_if #(
  parameter int ROW_W = 9,
  parameter int COL_W = 10
);
  logic             frame_start;
  logic             pix_valid;
  logic             pix_ready;
  logic             win_start;
  logic [7:0]       grad_hs;
  logic [7:0]       grad_vs;
  logic [7:0]       grad_hf;
  logic [7:0]       grad_vf;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_grad;
  logic [ROW_W-1:0] out_row;
  logic [COL_W-1:0] out_col;
  logic             out_last;
  logic             busy;
  logic             frame_done;

  modport master (
    input  frame_start, pix_valid, grad_hs, grad_vs, grad_hf, grad_vf, out_ready,
    output pix_ready, win_start, out_valid, out_grad, out_row, out_col, out_last,
           busy, frame_done
  );

  modport slave (
    output frame_start, pix_valid, grad_hs, grad_vs, grad_hf, grad_vf, out_ready,
    input  pix_ready, win_start, out_valid, out_grad, out_row, out_col, out_last,
           busy, frame_done
  );
endinterface

// File: rtl/cfa_grad_scheduler.sv
// Frame sequencer for the 5x5 CFA gradient unit: issues one start per interior window,
// tags it with its centre, captures gradients GRAD_LAT cycles later into a credit-guarded FIFO.
module cfa_grad_scheduler #(
  parameter int IMG_W      = 640,
  parameter int IMG_H      = 480,
  parameter int COL_W      = 10,
  parameter int ROW_W      = 9,
  parameter int GRAD_LAT   = 3,
  parameter int FIFO_DEPTH = 4
) (
  input logic                 clk,
  input logic                 rst,
  cfa_grad_scheduler_if.master bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [CNT_W:0]   CREDITS  = (CNT_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  typedef struct packed {
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic             last;
  } tag_t;

  typedef struct packed {
    logic [31:0] grad;
    tag_t        tag;
  } entry_t;

  state_t           state, state_nxt;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;
  logic [CNT_W-1:0] inflight;
  logic [CNT_W-1:0] fifo_count;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  entry_t           mem [FIFO_DEPTH];
  logic [GRAD_LAT:0] tag_vld;
  tag_t             tag_pipe [GRAD_LAT+1];
  entry_t           head;

  logic win_pix, last_pix, has_credit, accept, issue, push, pop;

  assign win_pix    = (row >= ROW_W'(4)) && (col >= COL_W'(4));
  assign last_pix   = (row == ROW_LAST) && (col == COL_LAST);
  // inflight + fifo_count is the number of results already promised a FIFO slot
  assign has_credit = ({1'b0, fifo_count} + {1'b0, inflight}) < CREDITS;
  assign accept     = bus.pix_valid && bus.pix_ready;
  assign issue      = accept && win_pix;
  assign push       = tag_vld[GRAD_LAT];
  assign pop        = bus.out_valid && bus.out_ready;

  assign bus.pix_ready  = (state == RUN) && (!win_pix || has_credit);
  assign bus.win_start  = tag_vld[0];
  assign bus.busy       = (state != IDLE);
  assign bus.frame_done = (state == DONE);

  assign head          = mem[rd_ptr];
  assign bus.out_valid = (fifo_count != '0);
  assign bus.out_grad  = bus.out_valid ? head.grad     : '0;
  assign bus.out_row   = bus.out_valid ? head.tag.row  : '0;
  assign bus.out_col   = bus.out_valid ? head.tag.col  : '0;
  assign bus.out_last  = bus.out_valid ? head.tag.last : 1'b0;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.frame_start) state_nxt = RUN;
      RUN:     if (accept && last_pix) state_nxt = DRAIN;
      DRAIN:   if (inflight == '0 && fifo_count == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      row        <= '0;
      col        <= '0;
      inflight   <= '0;
      fifo_count <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      tag_vld    <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && bus.frame_start) begin
        row <= '0;
        col <= '0;
      end else if (accept) begin
        if (col == COL_LAST) begin
          col <= '0;
          row <= last_pix ? '0 : row + ROW_W'(1);
        end else begin
          col <= col + COL_W'(1);
        end
      end
      tag_vld    <= {tag_vld[GRAD_LAT-1:0], issue};
      inflight   <= inflight + CNT_W'(issue) - CNT_W'(push);
      fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // Payload registers carry no reset; their valid bits above qualify them.
  always_ff @(posedge clk) begin
    tag_pipe[0] <= '{row: row - ROW_W'(2), col: col - COL_W'(2), last: last_pix};
    for (int i = 1; i <= GRAD_LAT; i++) begin
      tag_pipe[i] <= tag_pipe[i-1];
    end
    if (push) begin
      mem[wr_ptr] <= '{grad: {bus.grad_hs, bus.grad_vs, bus.grad_hf, bus.grad_vf},
                       tag:  tag_pipe[GRAD_LAT]};
    end
  end

  fifo_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && fifo_count == CNT_W'(FIFO_DEPTH)));

endmodule

// File: tb/tb_cfa_grad_scheduler.sv
// Randomized scoreboard bench for cfa_grad_scheduler on an 8x6 frame with a 3-cycle gradient model.
module tb_cfa_grad_scheduler;
  localparam int W     = 8;
  localparam int H     = 6;
  localparam int LAT   = 3;
  localparam int DEPTH = 4;
  localparam int NWIN  = (W - 4) * (H - 4);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cfa_grad_scheduler_if #(.ROW_W(9), .COL_W(10)) bus ();

  cfa_grad_scheduler #(
    .IMG_W(W), .IMG_H(H), .COL_W(10), .ROW_W(9), .GRAD_LAT(LAT), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic [8:0]  r;
    logic [9:0]  c;
    logic [31:0] g;
    logic        last;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_pass = 0;

  int acc_cnt, acc_win, pops, win_idx, done_cnt, max_out, cyc;
  int t_acc, t_ws, t_ov;
  bit done_prev = 1'b0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, req);
  endfunction

  // k-th window of a frame in raster order, with the gradient model's values
  function automatic exp_t model(int idx);
    exp_t e;
    int r, c;
    logic [7:0] r8, c8;
    r = 2 + idx / (W - 4);
    c = 2 + idx % (W - 4);
    r8 = 8'(r);
    c8 = 8'(c);
    e.r    = 9'(r);
    e.c    = 10'(c);
    e.g    = {r8, c8, r8 + c8, ~r8};
    e.last = (r == H - 3) && (c == W - 3);
    return e;
  endfunction

  function automatic void reset_counts();
    acc_cnt = 0; acc_win = 0; pops = 0; win_idx = 0; done_cnt = 0; max_out = 0;
    t_acc = -1; t_ws = -1; t_ov = -1;
  endfunction

  // Gradient unit stand-in: values appear exactly LAT cycles after win_start
  logic [31:0] dly [4];
  bit          dly_v [4];
  always @(negedge clk) begin
    exp_t e;
    for (int i = 3; i > 0; i--) begin
      dly[i]   = dly[i-1];
      dly_v[i] = dly_v[i-1];
    end
    dly_v[0] = bus.win_start;
    if (bus.win_start) begin
      e = model(win_idx);
      dly[0] = e.g;
      win_idx++;
    end
    if (dly_v[3]) {bus.grad_hs, bus.grad_vs, bus.grad_hf, bus.grad_vf} = dly[3];
    else          {bus.grad_hs, bus.grad_vs, bus.grad_hf, bus.grad_vf} = $urandom;
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    exp_t e, got;
    cyc++;
    if (bus.pix_valid && bus.pix_ready) begin
      if (acc_cnt / W >= 4 && acc_cnt % W >= 4) begin
        check("credit_at_issue", 64'((acc_win - pops) < DEPTH), 64'd1);
        acc_win++;
      end
      if (acc_cnt == 4 * W + 4) t_acc = cyc;
      acc_cnt++;
    end
    if (bus.win_start && t_ws < 0) t_ws = cyc;
    if (bus.out_valid && t_ov < 0) t_ov = cyc;
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pop_queue_size", 64'(exp_q.size()), 64'd1);
      end else begin
        e   = exp_q.pop_front();
        got = '{r: bus.out_row, c: bus.out_col, g: bus.out_grad, last: bus.out_last};
        check("result", 64'(got), 64'(e));
      end
      pops++;
    end
    if (acc_win - pops > max_out) max_out = acc_win - pops;
    if (done_prev) check("busy_after_done", 64'(bus.busy), 64'd0);
    done_prev = bus.frame_done;
    if (bus.frame_done) done_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    reset_counts();
    for (int i = 0; i < NWIN; i++) exp_q.push_back(model(i));
    bus.frame_start = 1'b1;
    step();
    bus.frame_start = 1'b0;
  endtask

  // mode 0: hold inputs; 1: out_ready toggles, pix_valid random; 2: both random
  task automatic wait_done(int budget, int mode);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      if (mode == 1) begin
        bus.out_ready = ~bus.out_ready;
        bus.pix_valid = 1'($urandom_range(0, 1));
      end else if (mode == 2) begin
        bus.out_ready = ($urandom % 3) != 0;
        bus.pix_valid = ($urandom % 4) != 0;
      end
      step();
      n++;
    end
    if (done_cnt == 0) check("frame_timeout_done_cnt", 64'(done_cnt), 64'd1);
    bus.pix_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) step();
  endtask

  task automatic end_of_frame(string tag);
    check({tag, "_pops"}, 64'(pops), 64'(NWIN));
    check({tag, "_queue_left"}, 64'(exp_q.size()), 64'd0);
    check({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
    check({tag, "_max_outstanding_ok"}, 64'(max_out <= DEPTH), 64'd1);
  endtask

  initial begin
    int n;
    bus.frame_start = 1'b0;
    bus.pix_valid   = 1'b0;
    bus.out_ready   = 1'b0;
    reset_counts();
    repeat (3) step();
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_pix_ready", 64'(bus.pix_ready), 64'd0);
    check("rst_win_start", 64'(bus.win_start), 64'd0);
    check("rst_frame_done", 64'(bus.frame_done), 64'd0);
    check("rst_out_bus", 64'({bus.out_grad, bus.out_row, bus.out_col, bus.out_last}), 64'd0);
    rst = 1'b0;

    // Idle guard: offered pixels are not taken before frame_start
    bus.pix_valid = 1'b1;
    repeat (5) step();
    check("idle_no_accept", 64'(acc_cnt), 64'd0);
    check("idle_pix_ready", 64'(bus.pix_ready), 64'd0);

    // Full frame, continuous flow
    bus.out_ready = 1'b1;
    start_frame();
    wait_done(400, 0);
    check("lat_win_start", 64'(t_ws - t_acc), 64'd1);
    check("lat_out_valid", 64'(t_ov - t_acc), 64'd5);
    end_of_frame("s1");

    // Consumer stalled: credits must block at (5,4) while row 5 fills
    bus.out_ready = 1'b0;
    bus.pix_valid = 1'b1;
    start_frame();
    repeat (80) step();
    check("stall_acc_cnt", 64'(acc_cnt), 64'(5 * W + 4));
    check("stall_pix_ready", 64'(bus.pix_ready), 64'd0);
    check("stall_outstanding", 64'(acc_win - pops), 64'(DEPTH));
    check("stall_busy", 64'(bus.busy), 64'd1);
    bus.out_ready = 1'b1;
    wait_done(400, 0);
    end_of_frame("s2");

    // Toggling consumer, random producer
    bus.out_ready = 1'b0;
    start_frame();
    wait_done(1000, 1);
    end_of_frame("s3");

    // Abort mid-frame one cycle after (4,6) is accepted
    bus.pix_valid = 1'b1;
    bus.out_ready = 1'b1;
    start_frame();
    n = 0;
    while (acc_cnt < 4 * W + 7 && n < 200) begin
      step();
      n++;
    end
    check("abort_reached_4_6", 64'(acc_cnt), 64'(4 * W + 7));
    rst = 1'b1;
    bus.pix_valid = 1'b0;
    step();
    check("abort_out_valid", 64'(bus.out_valid), 64'd0);
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_win_start", 64'(bus.win_start), 64'd0);
    check("abort_pix_ready", 64'(bus.pix_ready), 64'd0);
    rst = 1'b0;
    exp_q.delete();
    reset_counts();
    repeat (10) step();
    check("abort_no_done", 64'(done_cnt), 64'd0);
    check("abort_no_output", 64'(pops), 64'd0);
    start_frame();
    wait_done(1000, 2);
    end_of_frame("s4");

    // frame_start mid-RUN is ignored; frame_start during DONE is ignored
    bus.pix_valid = 1'b1;
    bus.out_ready = 1'b1;
    start_frame();
    repeat (15) step();
    bus.frame_start = 1'b1;
    step();
    bus.frame_start = 1'b0;
    n = 0;
    while (!bus.frame_done && n < 400) begin
      bus.out_ready = ($urandom % 2) != 0;
      step();
      n++;
    end
    check("s5_reached_done", 64'(bus.frame_done), 64'd1);
    bus.frame_start = 1'b1;
    step();
    bus.frame_start = 1'b0;
    check("done_start_ignored_busy", 64'(bus.busy), 64'd0);
    check("done_start_ignored_ready", 64'(bus.pix_ready), 64'd0);
    bus.pix_valid = 1'b0;
    repeat (3) step();
    check("s5_acc_total", 64'(acc_cnt), 64'(W * H));
    end_of_frame("s5");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
